// File: rtl/fpga_template_pkg.sv
// Types and sizes shared by the ping-pong RAM (ram_logic) and its read-port arbiter.
package fpga_template_pkg;

   localparam int unsigned RAM_BUF_DEPTH = 256;
   localparam int unsigned RAM_WORD_W    = 36;

   typedef enum logic [1:0] {
      StIdle,
      StAnnounce,
      StStream,
      StDrain
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester after last_i wins, one-hot encoded.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic               valid_o
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      valid_o   = 1'b0;
      idx       = '0;
      // Offsets 1..NUM_REQ so the previous winner is checked last.
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = IDX_W'((32'(last_i) + k) % NUM_REQ);
         if (!valid_o && req_i[idx]) begin
            valid_o    = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = idx;
         end
      end
   end

endmodule

// File: rtl/ram_read_arbiter.sv
// Grants whole RAM buffers to NUM_REQ consumers round-robin; unclaimed buffers are drained.
module ram_read_arbiter
   import fpga_template_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned DATA_W    = RAM_WORD_W,
   parameter int unsigned BUF_DEPTH = RAM_BUF_DEPTH
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [DATA_W-1:0]  ram_read_data_i,
   input  logic               ram_read_valid_i,
   output logic               ram_read_ready_o,
   input  logic               ram_buffer_ready_i,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] buffer_ready_o,
   output logic [DATA_W-1:0]  read_data_o,
   output logic [NUM_REQ-1:0] read_valid_o,
   input  logic [NUM_REQ-1:0] read_ready_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic               busy_o,
   output logic [7:0]         drop_count_o
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

   arb_state_e         state_q, state_d;
   logic               pending_q, pending_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [7:0]         drop_q, drop_d;

   logic [NUM_REQ-1:0] rr_gnt;
   logic [IDX_W-1:0]   rr_idx;
   logic               rr_valid;
   logic               xfer, last_word, arbitrate;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req_i     (req_i),
      .last_i    (last_q),
      .gnt_o     (rr_gnt),
      .gnt_idx_o (rr_idx),
      .valid_o   (rr_valid)
   );

   assign read_data_o  = ram_read_data_i;
   assign grant_o      = grant_q;
   assign busy_o       = (state_q != StIdle);
   assign drop_count_o = drop_q;

   // Port routing follows the registered grant; ANNOUNCE already streams.
   always_comb begin
      ram_read_ready_o = 1'b0;
      read_valid_o     = '0;
      buffer_ready_o   = '0;
      case (state_q)
         StAnnounce: begin
            buffer_ready_o   = grant_q;
            ram_read_ready_o = |(read_ready_i & grant_q);
            read_valid_o     = grant_q & {NUM_REQ{ram_read_valid_i}};
         end
         StStream: begin
            ram_read_ready_o = |(read_ready_i & grant_q);
            read_valid_o     = grant_q & {NUM_REQ{ram_read_valid_i}};
         end
         StDrain:  ram_read_ready_o = 1'b1;
         default:  ;
      endcase
   end

   assign xfer      = ram_read_valid_i & ram_read_ready_o;
   assign last_word = xfer && (cnt_q == CNT_W'(BUF_DEPTH - 1));

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      cnt_d     = cnt_q;
      grant_d   = grant_q;
      last_d    = last_q;
      drop_d    = drop_q;
      arbitrate = 1'b0;

      if (ram_buffer_ready_i && pending_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      if (ram_buffer_ready_i) pending_d = 1'b1;

      if (state_q == StIdle) begin
         arbitrate = pending_q | ram_buffer_ready_i;
      end else begin
         if (state_q == StAnnounce) state_d = StStream;
         if (xfer) cnt_d = cnt_q + CNT_W'(1);
         if (last_word) begin
            cnt_d     = '0;
            arbitrate = pending_q | ram_buffer_ready_i;
            if (!arbitrate) begin
               state_d = StIdle;
               grant_d = '0;
            end
         end
      end

      if (arbitrate) begin
         pending_d = 1'b0;
         if (rr_valid) begin
            state_d = StAnnounce;
            grant_d = rr_gnt;
            last_d  = rr_idx;
         end else begin
            state_d = StDrain;
            grant_d = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         pending_q <= 1'b0;
         cnt_q     <= '0;
         grant_q   <= '0;
         last_q    <= IDX_W'(NUM_REQ - 1);
         drop_q    <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         drop_q    <= drop_d;
      end
   end

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Self-checking bench: buffer-level reference model checked every cycle, plus directed sequences.
module tb_ram_read_arbiter;

   localparam int NR    = 2;
   localparam int DW    = 36;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic [DW-1:0] ram_read_data_i = '0;
   logic          ram_read_valid_i = 1'b0;
   logic          ram_read_ready_o;
   logic          ram_buffer_ready_i = 1'b0;
   logic [NR-1:0] req_i = '0;
   logic [NR-1:0] buffer_ready_o;
   logic [DW-1:0] read_data_o;
   logic [NR-1:0] read_valid_o;
   logic [NR-1:0] read_ready_i = '0;
   logic [NR-1:0] grant_o;
   logic          busy_o;
   logic [7:0]    drop_count_o;

   ram_read_arbiter #(
      .NUM_REQ   (NR),
      .DATA_W    (DW),
      .BUF_DEPTH (DEPTH)
   ) dut (
      .clk_i              (clk),
      .rst_ni             (rst_ni),
      .ram_read_data_i    (ram_read_data_i),
      .ram_read_valid_i   (ram_read_valid_i),
      .ram_read_ready_o   (ram_read_ready_o),
      .ram_buffer_ready_i (ram_buffer_ready_i),
      .req_i              (req_i),
      .buffer_ready_o     (buffer_ready_o),
      .read_data_o        (read_data_o),
      .read_valid_o       (read_valid_o),
      .read_ready_i       (read_ready_i),
      .grant_o            (grant_o),
      .busy_o             (busy_o),
      .drop_count_o       (drop_count_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model: one buffer in flight, owner -1 means drained internally.
   bit m_active, m_announce, m_pending;
   int m_owner, m_left, m_last, m_drops;

   // Bench observations.
   int beats0, beats1_seen, idle_cycles;
   int grant_log[$];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_announce = 0; m_pending = 0;
      m_owner = -1; m_left = 0; m_last = NR - 1; m_drops = 0;
   endtask

   task automatic model_arbitrate(input logic [NR-1:0] req);
      m_owner = -1;
      for (int k = 1; k <= NR; k++) begin
         int i;
         i = (m_last + k) % NR;
         if (m_owner < 0 && req[i]) m_owner = i;
      end
      if (m_owner >= 0) begin
         m_last = m_owner;
         m_announce = 1;
      end
      m_active = 1;
      m_left = DEPTH;
      m_pending = 0;
   endtask

   // Drive one cycle's inputs, compare all outputs with the model, advance one clock.
   task automatic step(input bit pulse, input bit valid, input logic [NR-1:0] rdy,
                       input logic [NR-1:0] req);
      logic [NR-1:0] e_grant, e_bufrdy, e_rv;
      logic          e_rdy;
      logic [63:0]   got, want;
      bit            trig, fin;
      ram_buffer_ready_i = pulse;
      ram_read_valid_i   = valid;
      read_ready_i       = rdy;
      req_i              = req;
      ram_read_data_i    = DW'({$urandom(), $urandom()});
      #1;
      e_grant  = (m_active && m_owner >= 0) ? NR'(1 << m_owner) : '0;
      e_bufrdy = m_announce ? e_grant : '0;
      e_rdy    = !m_active ? 1'b0 : (m_owner < 0) ? 1'b1 : rdy[m_owner];
      e_rv     = valid ? e_grant : '0;
      got  = 64'({busy_o, grant_o, buffer_ready_o, ram_read_ready_o, read_valid_o,
                  drop_count_o, read_data_o});
      want = 64'({m_active, e_grant, e_bufrdy, e_rdy, e_rv, 8'(m_drops), ram_read_data_i});
      check("cycle_outputs", got, want);

      if (read_valid_o[0] && read_ready_i[0]) beats0++;
      if (read_valid_o[1]) beats1_seen++;
      if (!busy_o) idle_cycles++;
      if (buffer_ready_o != '0) grant_log.push_back(buffer_ready_o[1] ? 1 : 0);

      trig = 0;
      fin  = 0;
      if (pulse && m_pending && m_drops < 255) m_drops++;
      if (m_active) begin
         m_announce = 0;
         if (valid && e_rdy) begin
            m_left--;
            fin = (m_left == 0);
         end
         if (fin) trig = m_pending || pulse;
         else if (pulse) m_pending = 1;
         if (fin && !trig) begin
            m_active = 0;
            m_owner = -1;
         end
      end else begin
         trig = m_pending || pulse;
      end
      if (trig) model_arbitrate(req);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      ram_buffer_ready_i = 1'b0;
      ram_read_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      model_reset();
   endtask

   task automatic run_to_idle(input string name, input logic [NR-1:0] rdy,
                              input logic [NR-1:0] req, input int max);
      for (int k = 0; k < max && busy_o; k++) step(0, 1, rdy, req);
      check(name, 64'(busy_o), 64'd0);
   endtask

   typedef struct {
      logic          valid;
      logic [NR-1:0] rdy;
      logic          exp_rrdy;
      logic [NR-1:0] exp_rv;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int n0, b0, c;
      vecs[0] = '{1'b1, 2'b10, 1'b1, 2'b10};
      vecs[1] = '{1'b1, 2'b01, 1'b0, 2'b10};
      vecs[2] = '{1'b0, 2'b10, 1'b1, 2'b00};
      vecs[3] = '{1'b0, 2'b00, 1'b0, 2'b00};
      vecs[4] = '{1'b1, 2'b11, 1'b1, 2'b10};
      vecs[5] = '{1'b1, 2'b00, 1'b0, 2'b10};
      beats0 = 0; beats1_seen = 0; idle_cycles = 0;

      // Reset values.
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", 64'({busy_o, grant_o, buffer_ready_o, ram_read_ready_o,
                                  read_valid_o, drop_count_o}), 64'd0);
      rst_ni = 1'b1;
      model_reset();

      // Single buffer to consumer 0.
      step(1, 1, 2'b01, 2'b01);
      check("t1_announce", 64'(buffer_ready_o), 64'b01);
      b0 = beats0;
      run_to_idle("t1_idle", 2'b01, 2'b01, 400);
      check("t1_beats0", 64'(beats0 - b0), 64'(DEPTH));
      check("t1_no_rv1", 64'(beats1_seen), 64'd0);

      // Four back-to-back buffers with both consumers requesting.
      do_reset();
      n0 = grant_log.size();
      c = 0;
      step(1, 1, 2'b11, 2'b11);
      while (busy_o && c < 1400) begin
         step((grant_log.size() - n0 < 4) && (c % 256 == 10), 1, 2'b11, 2'b11);
         c++;
      end
      check("t2_count", 64'(grant_log.size() - n0), 64'd4);
      for (int i = 0; i < 4; i++)
         if (n0 + i < grant_log.size()) check("t2_grant", 64'(grant_log[n0+i]), 64'(i % 2));
      check("t2_drops", 64'(drop_count_o), 64'd0);

      // Nobody requests: buffer drained, no announce.
      n0 = grant_log.size();
      step(1, 1, 2'b00, 2'b00);
      check("t3_drain_ready", 64'({busy_o, ram_read_ready_o, grant_o}), 64'b1100);
      run_to_idle("t3_idle", 2'b00, 2'b00, 300);
      check("t3_no_announce", 64'(grant_log.size() - n0), 64'd0);

      // Stalled consumer 0 with two extra notifications; last grant was 1, so 0 wins next.
      n0 = grant_log.size();
      step(1, 1, 2'b00, 2'b11);
      for (int k = 0; k < 1000; k++) step(k == 100 || k == 200, 1, 2'b00, 2'b01);
      check("t4_first_grant", 64'(grant_log[n0]), 64'd0);
      check("t4_drop", 64'(drop_count_o), 64'd1);
      idle_cycles = 0;
      for (int k = 0; k < 400 && grant_log.size() < n0 + 2; k++) step(0, 1, 2'b01, 2'b01);
      check("t4_second_announce", 64'(grant_log.size() - n0), 64'd2);
      check("t4_no_bubble", 64'(idle_cycles), 64'd0);
      run_to_idle("t4_idle", 2'b01, 2'b01, 400);

      // Drop counter saturation.
      step(1, 1, 2'b00, 2'b01);
      for (int k = 0; k < 602; k++) step(k % 2 == 0, 1, 2'b00, 2'b01);
      check("t5_saturate", 64'(drop_count_o), 64'd255);
      run_to_idle("t5_idle", 2'b01, 2'b01, 1200);

      // Reset in the middle of a buffer.
      step(1, 1, 2'b01, 2'b01);
      b0 = beats0;
      for (int k = 0; k < 300 && beats0 - b0 < 100; k++) step(0, 1, 2'b01, 2'b01);
      rst_ni = 1'b0;
      #1;
      check("t6_async_reset", 64'({busy_o, grant_o, buffer_ready_o, ram_read_ready_o,
                                   read_valid_o, drop_count_o}), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      model_reset();
      n0 = grant_log.size();
      b0 = beats0;
      step(1, 1, 2'b01, 2'b11);
      run_to_idle("t6_idle", 2'b01, 2'b01, 400);
      check("t6_grant0", 64'(grant_log[n0]), 64'd0);
      check("t6_full_count", 64'(beats0 - b0), 64'(DEPTH));

      // Routing table while consumer 1 owns the port.
      step(1, 1, 2'b00, 2'b10);
      step(0, 0, 2'b00, 2'b10);
      for (int i = 0; i < 6; i++) begin
         ram_read_valid_i = vecs[i].valid;
         read_ready_i     = vecs[i].rdy;
         #1;
         check("t7_ram_ready", 64'(ram_read_ready_o), 64'(vecs[i].exp_rrdy));
         check("t7_read_valid", 64'(read_valid_o), 64'(vecs[i].exp_rv));
         step(0, vecs[i].valid, vecs[i].rdy, 2'b10);
      end
      run_to_idle("t7_idle", 2'b10, 2'b10, 400);

      // Randomized traffic against the model.
      for (int k = 0; k < 8000; k++)
         step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
              NR'($urandom_range(0, 3) | $urandom_range(0, 3)), NR'($urandom_range(0, 3)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
